fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage that sits directly upstream of the instruction queue. It holds the architectural fetch PC and issues single-outstanding line requests to instruction memory. It keeps the last returned 64-bit line in a one-entry line buffer so the second instruction of a line costs no new request, and it presents one fetched instruction per cycle to the IQ as `fetch_valid` + `if_inst_out`. It stalls on `inst_queue_full` and redirects on `branch_incorrect`, including discarding an in-flight stale response.

## Interface
- `RESET_PC`, default 64'h0, PC loaded at reset.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `inst_queue_full` in 1: IQ cannot accept; suppresses the next fetch.
- `branch_incorrect` in 1: mispredict flush; same signal drives the IQ flush.
- `branch_target` in 64: redirect PC, valid with `branch_incorrect`.
- `Imem2proc_valid` in 1: one-cycle response strobe.
- `Imem2proc_data` in 64: line data; [31:0] is the instruction at addr+0, [63:32] is the instruction at addr+4.
- `proc2Imem_req` out 1: line request, combinational, one cycle per request.
- `proc2Imem_addr` out 64: `{pc[63:3],3'b000}`, valid while `proc2Imem_req`.
- `fetch_valid` out 1: registered; `if_inst_out` holds a new instruction.
- `if_inst_out` out INST_Q: registered; `valid_inst`, `npc` = pc+4, `ir`; all other fields are EMPTY_INST_Q values.
- `fetch_pc` out 64: current PC (debug).

## Operation
- State: `pc[63:0]`, `state` ∈ {FETCH, WAIT, DRAIN}, `lb_valid`, `lb_tag[60:0]`, `lb_data[63:0]`.
- Hit means `lb_valid && lb_tag == pc[63:3]`. Selected word is `pc[2] ? lb_data[63:32] : lb_data[31:0]`. `pc[1:0]` is ignored.
- FETCH:
  - `branch_incorrect`: `pc <= branch_target`; stay in FETCH; no request; `fetch_valid <= 0`.
  - Else hit and `!inst_queue_full`:
    - `fetch_valid <= 1`, `if_inst_out <= {valid_inst=1, npc=pc+4, ir=word}`, `pc <= pc+4`.
  - Else hit and full: `fetch_valid <= 0`; pc holds.
  - Else (miss), regardless of full:
    - `proc2Imem_req = 1` this cycle; go to WAIT.
    - `fetch_valid <= 0`.
  - Any `Imem2proc_valid` seen in FETCH is ignored.
- WAIT:
  - `branch_incorrect` (with or without a same-cycle response):
    - `pc <= branch_target`; response (if any) is discarded.
    - With no same-cycle response: go to DRAIN.
    - With a same-cycle response: go to FETCH.
  - Else `Imem2proc_valid`: `lb_valid <= 1`, `lb_tag <= pc[63:3]`, `lb_data <= Imem2proc_data`; go to FETCH.
  - Else hold.
  - `fetch_valid <= 0` throughout.
- DRAIN:
  - `branch_incorrect`: `pc <= branch_target`; remain in DRAIN unless a same-cycle response ends the drain.
  - `Imem2proc_valid`: discard the data; go to FETCH. The line buffer is not written.
  - `fetch_valid <= 0`.
- Exactly one request is outstanding at most. No request is issued in WAIT or DRAIN.
- The line buffer survives redirects. A redirect into the same line hits immediately.
- PC arithmetic is 64-bit modulo; `pc+4` wraps from 64'hFFFF_FFFF_FFFF_FFFC to 0.

## Timing
- Reset (async, immediate):
  - `pc = RESET_PC`, `state = FETCH`, `lb_valid = 0`.
  - `fetch_valid = 0`, `if_inst_out = EMPTY_INST_Q`, `proc2Imem_req = 0`, `proc2Imem_addr = {RESET_PC[63:3],3'b0}`.
  - Reset mid-WAIT/DRAIN abandons the request. Memory shares this reset, so no stale response follows.
- Hit latency: instruction visible on `fetch_valid` the cycle after the FETCH hit cycle; one instruction per cycle sustained within a line.
- Miss latency: request in cycle t, response in cycle t+k (k ≥ 1), fill at the t+k edge, hit at t+k+1, `fetch_valid` at t+k+2.
- Stall: `inst_queue_full` high in cycle t ⇒ `fetch_valid` = 0 in cycle t+1; PC holds.
- Redirect: `branch_incorrect` in cycle t ⇒ `fetch_valid` = 0 in cycle t+1, so no wrong-path instruction reaches the flushed IQ. The first target instruction appears no earlier than t+2.
- `branch_incorrect` and `inst_queue_full` together: the redirect wins.

## Test plan
- Reset with RESET_PC=0x100, memory latency 2: req at cycle 0 (addr 0x100). Response gives data 0xBBBB_BBBB_AAAA_AAAA. `fetch_valid` carries ir=0xAAAAAAAA, npc=0x104, then the next cycle ir=0xBBBBBBBB, npc=0x108. Then a req to 0x108.
- `inst_queue_full` held 3 cycles during a line hit: no `fetch_valid` during the 3 following cycles; resumes with the same PC; no instruction is lost or duplicated.
- `branch_incorrect` with target 0x200 while in WAIT for 0x108:
  - The 0x108 response arrives 2 cycles later and is dropped (line buffer tag unchanged).
  - The next req is 0x200.
  - No `fetch_valid` until the 0x200 data returns.
- Redirect in the same cycle as the WAIT response: data discarded; FETCH at target; req issued the next cycle.
- Redirect to 0x104 while the line buffer holds 0x100: no request; `fetch_valid` with ir=upper word, npc=0x108, two cycles after the redirect.
- Assert async reset mid-WAIT between clock edges: outputs clear immediately. After release, req to RESET_PC, `lb_valid` = 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// ============================================================================
// fetch_pkg : fetch-to-IQ instruction record type and its empty value
// Rev 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

    typedef struct packed {
        logic        valid_inst;
        logic        illegal;
        logic [63:0] pc;
        logic [63:0] npc;
        logic [31:0] ir;
    } INST_Q;

    // An empty slot carries a canonical NOP so downstream decode sees no side effects.
    localparam INST_Q EMPTY_INST_Q = '{
        valid_inst: 1'b0,
        illegal:    1'b0,
        pc:         64'h0,
        npc:        64'h0,
        ir:         32'h0000_0013
    };

endpackage

`default_nettype wire

// File: rtl/fetch_stage_if.sv
// ============================================================================
// fetch_stage_if : single-outstanding instruction-memory line request bus
// Rev 1.0
// ============================================================================
`default_nettype none

interface fetch_stage_if;
    logic        proc2Imem_req;
    logic [63:0] proc2Imem_addr;
    logic        Imem2proc_valid;
    logic [63:0] Imem2proc_data;

    modport master (
        output proc2Imem_req,
        output proc2Imem_addr,
        input  Imem2proc_valid,
        input  Imem2proc_data
    );

    modport slave (
        input  proc2Imem_req,
        input  proc2Imem_addr,
        output Imem2proc_valid,
        output Imem2proc_data
    );
endinterface

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// fetch_stage : PC + one-line buffer feeding the IQ one instruction per cycle
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  wire logic          clock,
    input  wire logic          reset,
    input  wire logic          inst_queue_full,
    input  wire logic          branch_incorrect,
    input  wire logic [63:0]   branch_target,
    fetch_stage_if.master      imem,
    output      logic          fetch_valid,
    output      INST_Q         if_inst_out,
    output      logic [63:0]   fetch_pc
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic        lb_valid_q, lb_valid_d;
    logic [60:0] lb_tag_q, lb_tag_d;
    logic [63:0] lb_data_q, lb_data_d;
    logic        fetch_valid_q, fetch_valid_d;
    INST_Q       if_inst_q, if_inst_d;

    logic        hit;
    logic [31:0] word;
    logic        req;

    assign hit  = lb_valid_q && (lb_tag_q == pc_q[63:3]);
    assign word = pc_q[2] ? lb_data_q[63:32] : lb_data_q[31:0];

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        lb_valid_d    = lb_valid_q;
        lb_tag_d      = lb_tag_q;
        lb_data_d     = lb_data_q;
        fetch_valid_d = 1'b0;
        if_inst_d     = if_inst_q;
        req           = 1'b0;

        case (state_q)
            FETCH: begin
                if (branch_incorrect) begin
                    pc_d = branch_target;
                end else if (hit) begin
                    if (!inst_queue_full) begin
                        fetch_valid_d        = 1'b1;
                        if_inst_d            = EMPTY_INST_Q;
                        if_inst_d.valid_inst = 1'b1;
                        if_inst_d.npc        = pc_q + 64'd4;
                        if_inst_d.ir         = word;
                        pc_d                 = pc_q + 64'd4;
                    end
                end else begin
                    req     = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A redirect kills the outstanding line; if its data is not
                // here yet, DRAIN absorbs it later so it never fills the buffer.
                if (branch_incorrect) begin
                    pc_d    = branch_target;
                    state_d = imem.Imem2proc_valid ? FETCH : DRAIN;
                end else if (imem.Imem2proc_valid) begin
                    lb_valid_d = 1'b1;
                    lb_tag_d   = pc_q[63:3];
                    lb_data_d  = imem.Imem2proc_data;
                    state_d    = FETCH;
                end
            end
            DRAIN: begin
                if (branch_incorrect) begin
                    pc_d = branch_target;
                end
                if (imem.Imem2proc_valid) begin
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            lb_valid_q    <= 1'b0;
            lb_tag_q      <= '0;
            lb_data_q     <= '0;
            fetch_valid_q <= 1'b0;
            if_inst_q     <= EMPTY_INST_Q;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            lb_valid_q    <= lb_valid_d;
            lb_tag_q      <= lb_tag_d;
            lb_data_q     <= lb_data_d;
            fetch_valid_q <= fetch_valid_d;
            if_inst_q     <= if_inst_d;
        end
    end

    // Gated by reset so no request escapes while state is being cleared.
    assign imem.proc2Imem_req  = req && !reset;
    assign imem.proc2Imem_addr = {pc_q[63:3], 3'b000};
    assign fetch_valid         = fetch_valid_q;
    assign if_inst_out         = if_inst_q;
    assign fetch_pc            = pc_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// tb_fetch_stage : directed + table-driven bench with memory model and scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fetch_stage;
    import fetch_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        full  = 1'b0;
    logic        bi    = 1'b0;
    logic [63:0] tgt   = 64'h0;
    logic        fetch_valid;
    INST_Q       if_inst_out;
    logic [63:0] fetch_pc;

    fetch_stage_if imem();

    fetch_stage #(.RESET_PC(64'h100)) dut (
        .clock            (clock),
        .reset            (reset),
        .inst_queue_full  (full),
        .branch_incorrect (bi),
        .branch_target    (tgt),
        .imem             (imem),
        .fetch_valid      (fetch_valid),
        .if_inst_out      (if_inst_out),
        .fetch_pc         (fetch_pc)
    );

    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_errors = 0;
    int          lat      = 2;
    INST_Q       exp_ins[$];
    logic [63:0] exp_req[$];

    function automatic logic [31:0] wrd(input logic [63:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    function automatic logic [63:0] mline(input logic [63:0] a);
        if (a == 64'h100) return 64'hBBBB_BBBB_AAAA_AAAA;
        return {wrd(a + 64'd4), wrd(a)};
    endfunction

    function automatic INST_Q mk(input logic [63:0] pc);
        INST_Q       e;
        logic [63:0] l;
        l            = mline({pc[63:3], 3'b000});
        e            = EMPTY_INST_Q;
        e.valid_inst = 1'b1;
        e.npc        = pc + 64'd4;
        e.ir         = pc[2] ? l[63:32] : l[31:0];
        return e;
    endfunction

    // Memory model + output monitor, all on the falling edge.
    initial begin : mem_model
        logic        pend;
        int          cnt;
        logic [63:0] paddr;
        INST_Q       e;
        logic [63:0] a;
        pend = 1'b0;
        cnt  = 0;
        paddr = '0;
        imem.Imem2proc_valid = 1'b0;
        imem.Imem2proc_data  = '0;
        forever begin
            @(negedge clock);
            imem.Imem2proc_valid = 1'b0;
            if (reset) begin
                pend = 1'b0;
            end else if (pend) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    imem.Imem2proc_valid = 1'b1;
                    imem.Imem2proc_data  = mline(paddr);
                    pend = 1'b0;
                end
            end
            if (!reset && fetch_valid) begin
                n_checks++;
                if (exp_ins.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_fetch got npc=%h ir=%h expected no fetch_valid",
                             if_inst_out.npc, if_inst_out.ir);
                end else begin
                    e = exp_ins.pop_front();
                    if (if_inst_out !== e) begin
                        n_errors++;
                        $display("FAIL fetch_inst got v=%b npc=%h ir=%h pc=%h expected v=%b npc=%h ir=%h pc=%h",
                                 if_inst_out.valid_inst, if_inst_out.npc, if_inst_out.ir, if_inst_out.pc,
                                 e.valid_inst, e.npc, e.ir, e.pc);
                    end
                end
            end
            if (!reset && imem.proc2Imem_req) begin
                n_checks++;
                if (pend) begin
                    n_errors++;
                    $display("FAIL second_outstanding got req addr=%h expected none", imem.proc2Imem_addr);
                end else if (exp_req.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_req got addr=%h expected none", imem.proc2Imem_addr);
                end else begin
                    a = exp_req.pop_front();
                    if (imem.proc2Imem_addr !== a) begin
                        n_errors++;
                        $display("FAIL req_addr got %h expected %h", imem.proc2Imem_addr, a);
                    end
                end
                pend  = 1'b1;
                cnt   = lat;
                paddr = imem.proc2Imem_addr;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic wait_q(input string name, input int maxc);
        for (int i = 0; i < maxc && (exp_req.size() != 0 || exp_ins.size() != 0); i++) tick();
        chk(name, 64'(exp_req.size() + exp_ins.size()), 64'd0);
    endtask

    task automatic wait_fv(input string name, input int maxc);
        for (int i = 0; i < maxc && !fetch_valid; i++) tick();
        chk(name, {63'd0, fetch_valid}, 64'd1);
    endtask

    typedef struct {
        logic [63:0] tgt;
        logic        full_b;
        logic        exp_fv;
        logic        exp_req;
        logic [63:0] exp_pc;
        logic [31:0] exp_ir;
        logic [63:0] exp_npc;
    } vec_t;

    initial begin : main
        vec_t  tbl[4];
        INST_Q e;

        // Redirects into the resident 0x200 line; last row runs off the line end.
        tbl[0] = '{64'h200, 1'b0, 1'b1, 1'b0, 64'h204, 32'hC0DE_0200, 64'h204};
        tbl[1] = '{64'h202, 1'b0, 1'b1, 1'b0, 64'h206, 32'hC0DE_0200, 64'h206};
        tbl[2] = '{64'h206, 1'b1, 1'b0, 1'b0, 64'h206, 32'h0,         64'h0};
        tbl[3] = '{64'h204, 1'b0, 1'b1, 1'b1, 64'h208, 32'hC0DE_0204, 64'h208};

        tick();
        tick();
        chk("rst_fetch_valid", {63'd0, fetch_valid}, 64'd0);
        chk("rst_req", {63'd0, imem.proc2Imem_req}, 64'd0);
        chk("rst_addr", imem.proc2Imem_addr, 64'h100);
        chk("rst_pc", fetch_pc, 64'h100);
        n_checks++;
        if (if_inst_out !== EMPTY_INST_Q) begin
            n_errors++;
            $display("FAIL rst_inst got ir=%h npc=%h expected empty", if_inst_out.ir, if_inst_out.npc);
        end

        // Cold start: miss at RESET_PC, both words, then next line.
        exp_req.push_back(64'h100);
        exp_ins.push_back(mk(64'h100));
        exp_ins.push_back(mk(64'h104));
        exp_req.push_back(64'h108);
        reset = 1'b0;
        wait_q("cold_start", 30);

        // Stall 3 cycles on the second word of line 0x108.
        exp_ins.push_back(mk(64'h108));
        exp_ins.push_back(mk(64'h10C));
        exp_req.push_back(64'h110);
        wait_fv("first_108", 20);
        full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_fv", {63'd0, fetch_valid}, 64'd0);
            chk("stall_pc", fetch_pc, 64'h10C);
        end
        full = 1'b0;
        lat  = 3;
        tick();
        chk("stall_resume", {63'd0, fetch_valid}, 64'd1);

        // Redirect while waiting for 0x110; its late response must be dropped.
        tick();
        bi  = 1'b1;
        tgt = 64'h200;
        exp_req.push_back(64'h200);
        exp_ins.push_back(mk(64'h200));
        tick();
        bi = 1'b0;
        chk("redirect_fv", {63'd0, fetch_valid}, 64'd0);
        wait_fv("first_200", 30);
        full = 1'b1;
        chk("hold_pc", fetch_pc, 64'h204);

        for (int r = 0; r < 4; r++) begin
            tick();
            bi   = 1'b1;
            tgt  = tbl[r].tgt;
            full = 1'b1;
            if (tbl[r].exp_fv) begin
                e            = EMPTY_INST_Q;
                e.valid_inst = 1'b1;
                e.ir         = tbl[r].exp_ir;
                e.npc        = tbl[r].exp_npc;
                exp_ins.push_back(e);
            end
            if (tbl[r].exp_req) exp_req.push_back(64'h208);
            tick();
            bi   = 1'b0;
            full = tbl[r].full_b;
            chk("vec_fv_after_redirect", {63'd0, fetch_valid}, 64'd0);
            tick();
            full = 1'b1;
            chk("vec_fv", {63'd0, fetch_valid}, {63'd0, tbl[r].exp_fv});
            chk("vec_pc", fetch_pc, tbl[r].exp_pc);
        end

        // Redirect in the same cycle as the response.
        for (int i = 0; i < 10 && !imem.Imem2proc_valid; i++) begin
            @(negedge clock);
            #1;
        end
        chk("resp_seen", {63'd0, imem.Imem2proc_valid}, 64'd1);
        bi  = 1'b1;
        tgt = 64'h300;
        exp_req.push_back(64'h300);
        tick();
        bi = 1'b0;
        chk("same_cycle_fv", {63'd0, fetch_valid}, 64'd0);
        chk("same_cycle_pc", fetch_pc, 64'h300);
        tick();
        chk("same_cycle_req_issued", 64'(exp_req.size()), 64'd0);

        // Async reset between edges while waiting for 0x300.
        #1;
        reset = 1'b1;
        #1;
        chk("async_rst_fv", {63'd0, fetch_valid}, 64'd0);
        chk("async_rst_pc", fetch_pc, 64'h100);
        chk("async_rst_req", {63'd0, imem.proc2Imem_req}, 64'd0);
        chk("async_rst_addr", imem.proc2Imem_addr, 64'h100);
        n_checks++;
        if (if_inst_out !== EMPTY_INST_Q) begin
            n_errors++;
            $display("FAIL async_rst_inst got ir=%h npc=%h expected empty", if_inst_out.ir, if_inst_out.npc);
        end
        full = 1'b0;
        tick();
        tick();
        // A stale valid buffer would hit on 0x200 without a request.
        exp_req.push_back(64'h100);
        exp_req.push_back(64'h200);
        exp_ins.push_back(mk(64'h200));
        exp_ins.push_back(mk(64'h204));
        exp_req.push_back(64'h208);
        reset = 1'b0;
        tick();
        bi  = 1'b1;
        tgt = 64'h200;
        tick();
        bi = 1'b0;
        wait_q("post_reset_refetch", 60);

        // PC wrap at the top of the address space.
        bi  = 1'b1;
        tgt = 64'hFFFF_FFFF_FFFF_FFFC;
        exp_req.push_back(64'hFFFF_FFFF_FFFF_FFF8);
        exp_ins.push_back(mk(64'hFFFF_FFFF_FFFF_FFFC));
        exp_req.push_back(64'h0);
        tick();
        bi = 1'b0;
        wait_q("wrap", 60);
        chk("wrap_pc", fetch_pc, 64'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
